// File: rtl/mem_io_ctrl_pkg.sv
// Shared definitions for the mem_io_ctrl memory / IO controller.
// Contents: access-size encodings, FSM state encoding, IO window constants,
// and the lane/alignment/extension helpers used by the datapath.
package mem_io_ctrl_pkg;

  // mem_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_IO_WAIT = 3'd2,
    ST_RESP    = 3'd3,
    ST_UART    = 3'd4
  } state_t;

  // IO window: every address with bits [31:10] set; channel index in [7:4]
  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
  localparam int          CH_LSB  = 4;
  localparam int          CH_MSB  = 7;

  // Low address bits actually used; half/word offsets are forced aligned
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: align_lo = lo;
      SIZE_HALF: align_lo = {lo[1], 1'b0};
      default:   align_lo = 2'b00;
    endcase
  endfunction

  // True when the low address bits do not suit the access size
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = lo[0];
      default:   is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  // Byte write enables for a store of the given size at the given offset
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: begin
        case (lo)
          2'b00:   lane_enables = 4'b0001;
          2'b01:   lane_enables = 4'b0010;
          2'b10:   lane_enables = 4'b0100;
          default: lane_enables = 4'b1000;
        endcase
      end
      SIZE_HALF: lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      default:   lane_enables = 4'b1111;
    endcase
  endfunction

  // Replicate store data so that every enabled lane sees the right bits
  function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: store_replicate = {4{data[7:0]}};
      SIZE_HALF: store_replicate = {2{data[15:0]}};
      default:   store_replicate = data;
    endcase
  endfunction

  // Right-align the addressed lane(s) and sign/zero extend
  function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] size,
                                              input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = data[7:0];
      2'b01:   b = data[15:8];
      2'b10:   b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lo[1] ? data[31:16] : data[15:0];
    case (size)
      SIZE_BYTE: load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_HALF: load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default:   load_extend = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_io_ctrl_ram.sv
// mem_byte_ram: 2^DEPTH x 32 word RAM with per-byte write enables and a
// single synchronous read port (read data valid the cycle after the address).
// Contents are never cleared by reset.
module mem_byte_ram #(
  parameter int DEPTH = 14
) (
  input  logic             clk,
  input  logic [DEPTH-1:0] i_addr,
  input  logic [3:0]       i_we,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [0:(1 << DEPTH) - 1];
  logic [31:0] r_rdata;

  // Byte-lane writes and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: CPU data-side controller routing loads/stores to a word RAM
// or to memory-mapped IO channels, with a UART ownership mode for loading
// the RAM. Optional feature macro: MISALIGN_TRAP_EN (suppresses misaligned
// accesses and adds the misalign output).
module mem_io_ctrl
  import mem_io_ctrl_pkg::*;
#(
  parameter int                     RAM_DEPTH   = 14,
  parameter int                     IO_CHANNELS = 4,
  parameter logic [IO_CHANNELS-1:0] IN_MASK     = 4'b0101
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [1:0]                  mem_size,
  input  logic                        mem_unsigned,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_store_data,
  output logic [31:0]                 mem_read_data,
  output logic                        mem_stall,
  output logic [IO_CHANNELS-1:0]      io_in_req,
  input  logic [IO_CHANNELS-1:0]      io_in_valid,
  input  logic [32*IO_CHANNELS-1:0]   io_in_data,
  output logic [IO_CHANNELS-1:0]      io_out_we,
  output logic [31:0]                 io_out_data,
  input  logic                        uart_mode,
  input  logic                        uart_we,
  input  logic [RAM_DEPTH-1:0]        uart_addr,
  input  logic [31:0]                 uart_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                        misalign
`endif
);

  localparam logic [15:0] IN_MASK16 = 16'(IN_MASK);

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_size, r_lo;
  logic                   r_uns;
  logic [3:0]             r_chan;
  logic [31:0]            r_io_data, r_read_data;

  logic                   w_access, w_is_read, w_is_write;
  logic                   w_ram_hit, w_io_region, w_chan_ok, w_chan_in;
  logic                   w_idle_free, w_misalign, w_take;
  logic                   w_ram_ld, w_ram_st, w_io_ld, w_io_st, w_drop_rd, w_capture;
  logic [3:0]             w_chan, w_cur_chan;
  logic [1:0]             w_lo;
  logic [15:0]            w_onehot16;
  logic [31:0]            w_in_sel;
  logic                   w_in_valid_sel;
  logic                   w_stall;
  logic [IO_CHANNELS-1:0] w_in_req, w_out_we;
  logic [31:0]            w_rdata_out;
  logic [3:0]             w_ram_we;
  logic [RAM_DEPTH-1:0]   w_ram_addr;
  logic [31:0]            w_ram_wdata, w_ram_q;

  // Address decode; both read and write asserted is treated as a write
  assign w_access    = req_valid & (mem_read | mem_write);
  assign w_is_write  = mem_write;
  assign w_is_read   = mem_read & ~mem_write;
  assign w_ram_hit   = (mem_addr[31:RAM_DEPTH+2] == '0);
  assign w_io_region = ((mem_addr & IO_BASE) == IO_BASE);
  assign w_chan      = mem_addr[CH_MSB:CH_LSB];
  assign w_chan_ok   = ({28'd0, w_chan} < 32'(IO_CHANNELS));
  assign w_chan_in   = IN_MASK16[w_chan];
  assign w_lo        = align_lo(mem_size, mem_addr[1:0]);

  // New requests are only taken in IDLE, outside reset and UART ownership
  assign w_idle_free = ~rst & ~uart_mode & (r_state == ST_IDLE);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_access & w_idle_free & is_misaligned(mem_size, mem_addr[1:0]);
  assign misalign   = w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_take    = w_access & w_idle_free & ~w_misalign;
  assign w_ram_ld  = w_take & w_is_read  & w_ram_hit;
  assign w_ram_st  = w_take & w_is_write & w_ram_hit;
  assign w_io_ld   = w_take & w_is_read  & w_io_region & w_chan_ok & w_chan_in;
  assign w_io_st   = w_take & w_is_write & w_io_region & w_chan_ok & ~w_chan_in;
  assign w_drop_rd = w_take & w_is_read  & ~w_ram_hit & ~w_io_ld;

  // Channel in play: the decoded one in IDLE, the latched one while waiting
  assign w_cur_chan = (r_state == ST_IDLE) ? w_chan : r_chan;
  assign w_onehot16 = 16'd1 << w_cur_chan;
  assign w_capture  = ~rst & ~uart_mode & w_in_valid_sel & (w_io_ld | (r_state == ST_IO_WAIT));

  // Select data/valid of the active input channel
  always_comb begin
    w_in_sel       = 32'd0;
    w_in_valid_sel = 1'b0;
    for (int k = 0; k < IO_CHANNELS; k++) begin
      w_in_sel       = (4'(k) == w_cur_chan) ? io_in_data[k*32 +: 32] : w_in_sel;
      w_in_valid_sel = (4'(k) == w_cur_chan) ? io_in_valid[k]         : w_in_valid_sel;
    end
  end

  // State register; reset overrides UART ownership and any request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (uart_mode) begin
      w_state_nxt = ST_UART;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ram_ld) begin
            w_state_nxt = ST_RD_WAIT;
          end else if (w_io_ld) begin
            w_state_nxt = w_in_valid_sel ? ST_RESP : ST_IO_WAIT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RD_WAIT: w_state_nxt = ST_IDLE;
        ST_IO_WAIT: w_state_nxt = w_in_valid_sel ? ST_RESP : ST_IO_WAIT;
        ST_RESP:    w_state_nxt = ST_IDLE;
        ST_UART:    w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output and RAM-port logic
  always_comb begin
    w_stall     = 1'b0;
    w_in_req    = {IO_CHANNELS{1'b0}};
    w_out_we    = {IO_CHANNELS{1'b0}};
    w_rdata_out = r_read_data;
    w_ram_we    = 4'h0;
    w_ram_addr  = mem_addr[RAM_DEPTH+1:2];
    w_ram_wdata = store_replicate(mem_size, mem_store_data);
    if (rst) begin
      w_rdata_out = 32'd0;
    end else if (uart_mode || (r_state == ST_UART)) begin
      w_stall = 1'b1;
      if ((r_state == ST_UART) && uart_mode && uart_we) begin
        w_ram_we    = 4'hF;
        w_ram_addr  = uart_addr;
        w_ram_wdata = uart_data;
      end else begin
        w_ram_we = 4'h0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_stall     = w_ram_ld | w_io_ld;
          w_in_req    = w_io_ld ? w_onehot16[IO_CHANNELS-1:0] : {IO_CHANNELS{1'b0}};
          w_out_we    = w_io_st ? w_onehot16[IO_CHANNELS-1:0] : {IO_CHANNELS{1'b0}};
          w_ram_we    = w_ram_st ? lane_enables(mem_size, w_lo) : 4'h0;
          w_rdata_out = w_drop_rd ? 32'd0 : r_read_data;
        end
        ST_RD_WAIT: w_rdata_out = load_extend(w_ram_q, r_size, r_lo, r_uns);
        ST_IO_WAIT: begin
          w_stall  = 1'b1;
          w_in_req = w_onehot16[IO_CHANNELS-1:0];
        end
        ST_RESP:    w_rdata_out = load_extend(r_io_data, r_size, r_lo, r_uns);
        default:    w_stall = 1'b0;
      endcase
    end
  end

  // Latch load attributes at acceptance, capture IO data, hold read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_size      <= SIZE_WORD;
      r_lo        <= 2'b00;
      r_uns       <= 1'b0;
      r_chan      <= 4'd0;
      r_io_data   <= 32'd0;
      r_read_data <= 32'd0;
    end else begin
      if (w_ram_ld || w_io_ld) begin
        r_size <= mem_size;
        r_lo   <= w_lo;
        r_uns  <= mem_unsigned;
        r_chan <= w_chan;
      end
      if (w_capture) begin
        r_io_data <= w_in_sel;
      end
      r_read_data <= w_rdata_out;
    end
  end

  mem_byte_ram #(
    .DEPTH(RAM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  assign mem_stall     = w_stall;
  assign io_in_req     = w_in_req;
  assign io_out_we     = w_out_we;
  assign io_out_data   = mem_store_data;
  assign mem_read_data = w_rdata_out;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed scenarios plus randomized
// RAM traffic compared against a byte-array reference model.
module tb_mem_io_ctrl;

  localparam int NCH = 4;

  logic               clk = 1'b0;
  logic               rst, req_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]         mem_size;
  logic [31:0]        mem_addr, mem_store_data, mem_read_data;
  logic               mem_stall;
  logic [NCH-1:0]     io_in_req, io_in_valid, io_out_we;
  logic [32*NCH-1:0]  io_in_data;
  logic [31:0]        io_out_data;
  logic               uart_mode, uart_we;
  logic [13:0]        uart_addr;
  logic [31:0]        uart_data;
`ifdef MISALIGN_TRAP_EN
  logic               misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [0:255];

  always #5 clk = ~clk;

  mem_io_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_store_data(mem_store_data), .mem_read_data(mem_read_data), .mem_stall(mem_stall),
    .io_in_req(io_in_req), .io_in_valid(io_in_valid), .io_in_data(io_in_data),
    .io_out_we(io_out_we), .io_out_data(io_out_data), .uart_mode(uart_mode), .uart_we(uart_we),
    .uart_addr(uart_addr), .uart_data(uart_data)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: little-endian byte memory, low bits ignored for half/word
  function automatic logic [31:0] mdl_load(input int a, input int sz, input bit uns);
    int base;
    logic [31:0] v;
    if (sz == 0) begin
      v = {24'd0, mdl[a]};
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      base = a - (a % 2);
      v = {16'd0, mdl[base+1], mdl[base]};
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      base = a - (a % 4);
      v = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
    end
    return v;
  endfunction

  task automatic mdl_store(input int a, input int sz, input logic [31:0] d);
    int base;
    if (sz == 0) begin
      mdl[a] = d[7:0];
    end else if (sz == 1) begin
      base = a - (a % 2);
      mdl[base] = d[7:0];
      mdl[base+1] = d[15:8];
    end else begin
      base = a - (a % 4);
      for (int i = 0; i < 4; i++) mdl[base+i] = d[i*8 +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] data, input logic uns);
    req_valid      = 1'b1;
    mem_read       = rd;
    mem_write      = wr;
    mem_size       = sz;
    mem_addr       = addr;
    mem_store_data = data;
    mem_unsigned   = uns;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
    drive(1'b0, 1'b1, sz, addr, data, 1'b0);
    #1;
    check("st_stall", 32'(mem_stall), 32'd0);
    step();
    set_idle();
    mdl_store(int'(addr), int'(sz), data);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] exp, input string tag);
    drive(1'b1, 1'b0, sz, addr, 32'd0, uns);
    #1;
    check({tag, "_stallN"}, 32'(mem_stall), 32'd1);
    step();
    #1;
    check({tag, "_stallN1"}, 32'(mem_stall), 32'd0);
    check({tag, "_data"}, mem_read_data, exp);
    step();
    set_idle();
    #1;
    check({tag, "_hold"}, mem_read_data, exp);
  endtask

  task automatic io_load(input int ch, input int delay, input logic [31:0] data, input string tag);
    drive(1'b1, 1'b0, 2'b10, 32'hFFFF_FC00 | 32'(ch << 4), 32'd0, 1'b0);
    io_in_data[ch*32 +: 32] = data;
    for (int i = 0; i <= delay; i++) begin
      io_in_valid = (i == delay) ? 4'(1 << ch) : 4'd0;
      #1;
      check({tag, "_stall"}, 32'(mem_stall), 32'd1);
      check({tag, "_req"}, 32'(io_in_req), 32'(1 << ch));
      step();
    end
    io_in_valid = 4'd0;
    #1;
    check({tag, "_resp_stall"}, 32'(mem_stall), 32'd0);
    check({tag, "_resp_req"}, 32'(io_in_req), 32'd0);
    check({tag, "_data"}, mem_read_data, data);
    step();
    set_idle();
  endtask

  task automatic drop(input logic rd, input logic wr, input logic [31:0] addr, input string tag);
    drive(rd, wr, 2'b10, addr, 32'h5555_AAAA, 1'b0);
    #1;
    check({tag, "_stall"}, 32'(mem_stall), 32'd0);
    check({tag, "_owe"}, 32'(io_out_we), 32'd0);
    if (rd) check({tag, "_data"}, mem_read_data, 32'd0);
    step();
    set_idle();
  endtask

  initial begin
    int a, sz;
    logic u;
    rst = 1'b1;
    set_idle();
    mem_size = 2'b10; mem_addr = 32'd0; mem_store_data = 32'd0; mem_unsigned = 1'b0;
    io_in_valid = 4'd0; io_in_data = '0;
    uart_mode = 1'b0; uart_we = 1'b0; uart_addr = 14'd0; uart_data = 32'd0;

    // Reset state, with a load and then an IO store presented during reset
    drive(1'b1, 1'b0, 2'b10, 32'h10, 32'd0, 1'b0);
    step();
    #1;
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_inreq", 32'(io_in_req), 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    drive(1'b0, 1'b1, 2'b10, 32'hFFFF_FC10, 32'h1, 1'b0);
    #1;
    check("rst_owe", 32'(io_out_we), 32'd0);
    step();
    rst = 1'b0;
    set_idle();
    step();

    // Fill bytes 0..63, then random mixed traffic against the model
    for (int n = 0; n < 16; n++) do_store(32'(n * 4), 2'b10, $urandom);
    for (int n = 0; n < 60; n++) begin
      a  = $urandom_range(0, 63);
      sz = $urandom_range(0, 2);
      u  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_store(32'(a), 2'(sz), $urandom);
      else do_load(32'(a), 2'(sz), u, mdl_load(a, sz, u), "rand_ld");
    end

    // Byte/half extension
    do_store(32'h10, 2'b10, 32'h8000_FF7F);
    do_load(32'h10, 2'b00, 1'b0, 32'h0000_007F, "lb_10");
    do_load(32'h11, 2'b00, 1'b0, 32'hFFFF_FFFF, "lb_11");
    do_load(32'h12, 2'b01, 1'b1, 32'h0000_8000, "lhu_12");
    do_load(32'h12, 2'b01, 1'b0, 32'hFFFF_8000, "lh_12");

    // Input channel reads: 5-cycle wait, same-cycle valid, random waits
    io_load(0, 5, 32'h0000_1234, "io_ch0");
    io_load(2, 0, 32'hCAFE_0002, "io_ch2_now");
    for (int n = 0; n < 4; n++) io_load((n % 2) * 2, $urandom_range(0, 4), $urandom, "io_rand");

    // Output channel write leaves RAM alone
    drive(1'b0, 1'b1, 2'b10, 32'hFFFF_FC10, 32'h0000_ABCD, 1'b0);
    #1;
    check("out_we", 32'(io_out_we), 32'h2);
    check("out_data", io_out_data, 32'h0000_ABCD);
    check("out_stall", 32'(mem_stall), 32'd0);
    step();
    set_idle();
    #1;
    check("out_we_after", 32'(io_out_we), 32'd0);
    do_load(32'h10, 2'b10, 1'b0, 32'h8000_FF7F, "ram_after_out");

    // No-op holds read data; dropped accesses
    drive(1'b0, 1'b0, 2'b10, 32'h10, 32'd0, 1'b0);
    #1;
    check("noop_stall", 32'(mem_stall), 32'd0);
    check("noop_hold", mem_read_data, 32'h8000_FF7F);
    step();
    set_idle();
    drop(1'b0, 1'b1, 32'hFFFF_FC00, "wr_in_ch");
    drop(1'b1, 1'b0, 32'hFFFF_FC10, "rd_out_ch");
    drop(1'b1, 1'b0, 32'h4000_0000, "rd_unmapped");
    drop(1'b1, 1'b0, 32'hFFFF_FC50, "rd_bad_ch");
    drop(1'b0, 1'b1, 32'hFFFF_FC50, "wr_bad_ch");

    // UART takes over during IO_WAIT
    drive(1'b1, 1'b0, 2'b10, 32'hFFFF_FC00, 32'd0, 1'b0);
    step();
    step();
    uart_mode = 1'b1;
    #1;
    check("uart_req_drop", 32'(io_in_req), 32'd0);
    check("uart_stall0", 32'(mem_stall), 32'd1);
    step();
    set_idle();
    uart_we = 1'b1; uart_addr = 14'd3; uart_data = 32'hDEAD_BEEF;
    #1;
    check("uart_stall1", 32'(mem_stall), 32'd1);
    step();
    uart_we = 1'b0; uart_mode = 1'b0;
    #1;
    check("uart_stall2", 32'(mem_stall), 32'd1);
    step();
    mdl_store(12, 2, 32'hDEAD_BEEF);
    do_load(32'hC, 2'b10, 1'b0, 32'hDEAD_BEEF, "uart_word3");

    // Reset in RD_WAIT and in IO_WAIT
    drive(1'b1, 1'b0, 2'b10, 32'h10, 32'd0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_idle();
    #1;
    check("rst_rd_stall", 32'(mem_stall), 32'd0);
    check("rst_rd_rdata", mem_read_data, 32'd0);
    drive(1'b1, 1'b0, 2'b10, 32'hFFFF_FC00, 32'd0, 1'b0);
    step();
    #1;
    check("pre_rst_io_req", 32'(io_in_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_idle();
    #1;
    check("rst_io_stall", 32'(mem_stall), 32'd0);
    check("rst_io_req", 32'(io_in_req), 32'd0);
    do_load(32'h10, 2'b10, 1'b0, 32'h8000_FF7F, "ram_kept");

    // Misaligned half store at 0x21
    do_store(32'h20, 2'b10, 32'h1122_3344);
`ifdef MISALIGN_TRAP_EN
    drive(1'b0, 1'b1, 2'b01, 32'h21, 32'h0000_BEEF, 1'b0);
    #1;
    check("misalign_pulse", 32'(misalign), 32'd1);
    step();
    set_idle();
    #1;
    check("misalign_clear", 32'(misalign), 32'd0);
    do_load(32'h20, 2'b10, 1'b0, 32'h1122_3344, "misalign_ram");
`else
    do_store(32'h21, 2'b01, 32'h0000_BEEF);
    do_load(32'h20, 2'b10, 1'b0, 32'h1122_BEEF, "misalign_lanes");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have parameter RAM_DEPTH, 14, log2 of RAM word count (RAM spans bytes 0 .. 4*2^RAM_DEPTH-1).
REQ-002 SHALL have parameter IO_CHANNELS, 4, number of IO channels (1..16).
REQ-003 SHALL have parameter IN_MASK, 4'b0101, bit k=1 makes channel k an input channel, 0 an output channel.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports req_valid in 1 (access present, i.e. not no_op); mem_read in 1; mem_write in 1; mem_size in 2 (00 byte, 01 half, 10 word); mem_unsigned in 1 (zero-extend loads).
REQ-007 SHALL have ports mem_addr in 32 (byte address); mem_store_data in 32; mem_read_data out 32; mem_stall out 1 (freeze pipeline).
REQ-008 SHALL have ports io_in_req out IO_CHANNELS; io_in_valid in IO_CHANNELS; io_in_data in 32*IO_CHANNELS; io_out_we out IO_CHANNELS; io_out_data out 32.
REQ-009 SHALL have ports uart_mode in 1 (UART owns RAM); uart_we in 1; uart_addr in RAM_DEPTH (word address); uart_data in 32.
REQ-010 SHALL have port misalign out 1 only when MISALIGN_TRAP_EN is defined.

Function
REQ-011 SHALL decode IO region as mem_addr[31:10] all ones; channel k = mem_addr[7:4], valid only if k < IO_CHANNELS.
REQ-012 SHALL decode RAM region as mem_addr < 4*2^RAM_DEPTH; any other address or invalid channel is unmapped.
REQ-013 SHALL use FSM states IDLE, RD_WAIT, IO_WAIT, RESP, UART.
REQ-014 RAM store SHALL complete in acceptance cycle, no stall, byte lanes from mem_size and mem_addr[1:0] (byte: lane addr[1:0]; half: lanes addr[1]*2+{0,1}; word: all).
REQ-015 RAM load SHALL assert mem_stall in acceptance cycle N (IDLE->RD_WAIT), present extended data with mem_stall=0 in cycle N+1, then return to IDLE.
REQ-016 Loads SHALL right-align selected lane(s) and sign-extend unless mem_unsigned=1; word loads unmodified.
REQ-017 Input-channel read SHALL enter IO_WAIT, hold io_in_req[k]=1 and mem_stall=1 until io_in_valid[k]=1, capture io_in_data[k] that cycle, go to RESP, present data with mem_stall=0, then IDLE.
REQ-018 io_in_valid arriving in the same cycle as the request SHALL still cost one stall cycle (capture, then RESP).
REQ-019 Output-channel write SHALL pulse io_out_we[k] for exactly the acceptance cycle with io_out_data=mem_store_data; RAM not written; no stall.
REQ-020 Write to input channel, read from output channel, or unmapped access SHALL be dropped; reads return 0; no stall.
REQ-021 req_valid=0 or mem_read=mem_write=0 SHALL cause no RAM write, no io strobe, no state change.
REQ-022 uart_mode=1 SHALL force state UART from any state (aborting IO_WAIT/RD_WAIT, dropping io_in_req), hold mem_stall=1, ignore CPU requests.
REQ-023 In UART, uart_we=1 SHALL write uart_data to word uart_addr same edge; uart_mode falling SHALL return to IDLE next cycle.
REQ-024 mem_read_data SHALL hold its last value outside RD_WAIT/RESP response cycles.

Reset
REQ-025 rst=1 SHALL force IDLE, mem_stall=0, io_in_req=0, io_out_we=0, mem_read_data=0, misalign=0, regardless of current state; RAM contents are not cleared.
REQ-026 rst SHALL take priority over uart_mode and any request in the same cycle.

Configuration
REQ-027 Macro MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word with addr[1:0]!=0 SHALL be suppressed (no write, no strobe, no stall) and misalign SHALL pulse 1 cycle.
REQ-028 Macro MISALIGN_TRAP_EN undefined: offending low address bits SHALL be treated as zero; port misalign absent.

Structure
REQ-029 Shared package SHALL hold mem_size encodings, FSM state encoding, IO base constant 0xFFFFFC00 and channel field bit positions.
REQ-030 Storage SHALL be sub-module mem_byte_ram: 2^RAM_DEPTH x 32, four byte write enables, one synchronous read port.

Verification
REQ-031 sw 0x8000FF7F @0x10; lb @0x10 -> 0x0000007F cycle N+1; lb @0x11 -> 0xFFFFFFFF; lhu @0x12 -> 0x00008000; mem_stall high only cycle N.
REQ-032 lw @0xFFFFFC00 (ch0 input), io_in_valid[0] after 5 cycles with 0x1234 -> io_in_req[0] and stall 6 cycles, then 0x00001234, stall 0.
REQ-033 sw 0xABCD @0xFFFFFC10 (ch1 output) -> io_out_we=4'b0010 one cycle, io_out_data=0xABCD, RAM @0x10 unchanged.
REQ-034 uart_mode=1 during IO_WAIT, uart_we word 3 =0xDEADBEEF, uart_mode=0 -> io_in_req drops, stall held, then lw @0xC returns 0xDEADBEEF.
REQ-035 rst pulse in RD_WAIT and in IO_WAIT -> next cycle IDLE, stall 0, io_in_req 0.
REQ-036 With MISALIGN_TRAP_EN: sh @0x21 -> misalign 1 cycle, RAM unchanged; without: stores to 0x20 lanes 0-1.
